// File: rtl/alu_mac_seq.sv
// Multi-cycle multiply-accumulate sequencer that drives the shared Alu through X_MUL then X_ADD per operand pair.
// Build option: define ALU_MAC_SEQ_EXACT_ACC_EN to accumulate with the exact adder (__ALU_ADD__).

`ifndef __ALU_ADD__
`define __ALU_ADD__ 4'd0
`endif
`ifndef __ALU_X_MUL__
`define __ALU_X_MUL__ 4'd12
`endif
`ifndef __ALU_X_ADD__
`define __ALU_X_ADD__ 4'd13
`endif

module alu_mac_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      init_i,
  input  logic             abort_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  output logic [3:0]       alu_sel_o,
  input  logic [31:0]      alu_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      result_o
);

`ifdef ALU_MAC_SEQ_EXACT_ACC_EN
  localparam logic [3:0] ACC_SEL = `__ALU_ADD__;
`else
  localparam logic [3:0] ACC_SEL = `__ALU_X_ADD__;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_OP,
    S_MUL,
    S_ACC,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [31:0]      acc_q;
  logic [31:0]      prod_q;
  logic [31:0]      opa_q;
  logic [31:0]      opb_q;
  logic [31:0]      result_q;
  logic [LEN_W-1:0] rem_q;

  // Abort wins over every transition; an operand handshaked alongside it is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      prod_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
    end else if (abort_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            acc_q   <= init_i;
            rem_q   <= len_i;
            state_q <= (len_i == '0) ? S_DONE : S_WAIT_OP;
          end
        end
        S_WAIT_OP: begin
          if (op_valid_i) begin
            opa_q   <= op_a_i;
            opb_q   <= op_b_i;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          prod_q  <= alu_out_i;
          state_q <= S_ACC;
        end
        S_ACC: begin
          acc_q   <= alu_out_i;
          rem_q   <= rem_q - 1'b1;
          state_q <= (rem_q == LEN_W'(1)) ? S_DONE : S_WAIT_OP;
        end
        S_DONE: begin
          result_q <= acc_q;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Alu ports depend only on registered state so nothing combinational loops back through the Alu.
  always_comb begin
    alu_a_o   = '0;
    alu_b_o   = '0;
    alu_sel_o = `__ALU_ADD__;
    case (state_q)
      S_MUL: begin
        alu_a_o   = opa_q;
        alu_b_o   = opb_q;
        alu_sel_o = `__ALU_X_MUL__;
      end
      S_ACC: begin
        alu_a_o   = prod_q;
        alu_b_o   = acc_q;
        alu_sel_o = ACC_SEL;
      end
      default: ;
    endcase
  end

  assign op_ready_o = (state_q == S_WAIT_OP);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign result_o   = result_q;

endmodule

// File: tb/tb_alu_mac_seq.sv
// Directed bench for alu_mac_seq with a stub Alu (X_MUL=A*B, X_ADD=A+B+1, ADD=A+B).

`ifndef __ALU_ADD__
`define __ALU_ADD__ 4'd0
`endif
`ifndef __ALU_X_MUL__
`define __ALU_X_MUL__ 4'd12
`endif
`ifndef __ALU_X_ADD__
`define __ALU_X_ADD__ 4'd13
`endif

module tb_alu_mac_seq;

`ifdef ALU_MAC_SEQ_EXACT_ACC_EN
  localparam logic [31:0] INC     = 32'd0;
  localparam logic [3:0]  ACC_SEL = `__ALU_ADD__;
`else
  localparam logic [31:0] INC     = 32'd1;
  localparam logic [3:0]  ACC_SEL = `__ALU_X_ADD__;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [31:0] init_v;
  logic        abort;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] pa [4];
  logic [31:0] pb [4];

  always #5 clk = ~clk;

  alu_mac_seq #(.LEN_W(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .len_i      (len),
    .init_i     (init_v),
    .abort_i    (abort),
    .op_valid_i (op_valid),
    .op_ready_o (op_ready),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_sel_o  (alu_sel),
    .alu_out_i  (alu_out),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result)
  );

  always_comb begin
    alu_out = '0;
    case (alu_sel)
      `__ALU_X_MUL__: alu_out = alu_a * alu_b;
      `__ALU_X_ADD__: alu_out = alu_a + alu_b + 32'd1;
      `__ALU_ADD__:   alu_out = alu_a + alu_b;
      default:        alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", tag, cyc, got, exp);
    end else begin
      $display("ok   %s cycle=%0d value=0x%08h", tag, cyc, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Caller sets pa/pb; starts in IDLE at cycle 0 and returns one cycle after DONE.
  task automatic run_job(input string tag, input int n, input logic [31:0] init,
                         input int stall, input int exp_done_cyc, input logic [31:0] exp_res);
    logic [31:0] acc_m;
    acc_m  = init;
    start  = 1'b1;
    len    = 8'(n);
    init_v = init;
    cyc    = 0;
    step();
    start  = 1'b0;
    for (int k = 0; k < n; k++) begin
      op_valid = 1'b0;
      for (int s = 0; s < stall; s++) begin
        check({tag, ":stall_ready"}, {31'd0, op_ready}, 32'd1);
        step();
      end
      op_valid = 1'b1;
      op_a     = pa[k];
      op_b     = pb[k];
      check({tag, ":wait_ready"}, {31'd0, op_ready}, 32'd1);
      step();
      if (stall > 0) op_valid = 1'b0;
      check({tag, ":mul_sel"}, {28'd0, alu_sel}, {28'd0, `__ALU_X_MUL__});
      check({tag, ":mul_a"}, alu_a, pa[k]);
      check({tag, ":mul_b"}, alu_b, pb[k]);
      check({tag, ":mul_ready"}, {31'd0, op_ready}, 32'd0);
      step();
      check({tag, ":acc_sel"}, {28'd0, alu_sel}, {28'd0, ACC_SEL});
      check({tag, ":acc_a"}, alu_a, pa[k] * pb[k]);
      check({tag, ":acc_b"}, alu_b, acc_m);
      acc_m = pa[k] * pb[k] + acc_m + INC;
      step();
    end
    op_valid = 1'b0;
    check({tag, ":done_cycle"}, 32'(cyc), 32'(exp_done_cyc));
    check({tag, ":done"}, {31'd0, done}, 32'd1);
    check({tag, ":done_ready"}, {31'd0, op_ready}, 32'd0);
    step();
    check({tag, ":done_drop"}, {31'd0, done}, 32'd0);
    check({tag, ":idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, ":result"}, result, exp_res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; init_v = '0; abort = 1'b0;
    op_valid = 1'b0; op_a = '0; op_b = '0;
    step();
    step();
    check("rst:busy", {31'd0, busy}, 32'd0);
    check("rst:done", {31'd0, done}, 32'd0);
    check("rst:ready", {31'd0, op_ready}, 32'd0);
    check("rst:result", result, 32'd0);
    check("rst:alu_a", alu_a, 32'd0);
    check("rst:alu_b", alu_b, 32'd0);
    check("rst:alu_sel", {28'd0, alu_sel}, {28'd0, `__ALU_ADD__});
    rst = 1'b0;
    step();

    // Zero length: DONE in cycle 1, ready never raised.
    run_job("zero", 0, 32'h55, 0, 1, 32'h55);
    check("zero:ready_after", {31'd0, op_ready}, 32'd0);

    // Back-to-back: products 6,20,1 -> 27 plus one per X_ADD.
    pa[0] = 2; pb[0] = 3; pa[1] = 4; pb[1] = 5; pa[2] = 1; pb[2] = 1;
    run_job("b2b", 3, 32'd0, 0, 10, 32'd27 + 3 * INC);

    // Stalled stream: 9 + 10 + 100 = 119 plus two X_ADD increments.
    pa[0] = 3; pb[0] = 3; pa[1] = 5; pb[1] = 2;
    run_job("stall", 2, 32'd100, 5, 17, 32'd119 + 2 * INC);

    // Leave 0x40 in result_o before the abort test.
    pa[0] = 0; pb[0] = 0;
    run_job("pre", 1, 32'h40 - INC, 0, 4, 32'h40);

    // Abort during the second ACC of a length-4 job.
    start = 1'b1; len = 8'd4; init_v = 32'd7; cyc = 0;
    step();
    start = 1'b0; op_valid = 1'b1; op_a = 32'd1; op_b = 32'd1;
    repeat (5) step();
    check("abort:in_acc", {28'd0, alu_sel}, {28'd0, ACC_SEL});
    abort = 1'b1;
    step();
    abort = 1'b0; op_valid = 1'b0;
    check("abort:busy", {31'd0, busy}, 32'd0);
    check("abort:done", {31'd0, done}, 32'd0);
    check("abort:result", result, 32'h40);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort:no_done", {31'd0, done}, 32'd0);
    end
    check("abort:result_hold", result, 32'h40);
    pa[0] = 3; pb[0] = 4;
    run_job("post_abort", 1, 32'd0, 0, 4, 32'd12 + INC);

    // Wrap-around with a start asserted mid-job.
    start = 1'b1; len = 8'd1; init_v = 32'hFFFF_FFFF; cyc = 0;
    step();
    start = 1'b1; len = 8'd5; init_v = 32'd0;
    op_valid = 1'b1; op_a = 32'd1; op_b = 32'd1;
    step();
    start = 1'b0; op_valid = 1'b0;
    check("wrap:mul_a", alu_a, 32'd1);
    step();
    check("wrap:acc_b", alu_b, 32'hFFFF_FFFF);
    step();
    check("wrap:done", {31'd0, done}, 32'd1);
    step();
    check("wrap:result", result, 32'hFFFF_FFFF + 32'd2 + INC - 32'd1);
    check("wrap:idle", {31'd0, busy}, 32'd0);
    step();
    check("wrap:no_restart", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
